// File: rtl/i2c_rx_ctrl.sv
// I2C slave receive control: frames bytes on SCL rising edges, matches the
// address, drives ACK/NACK and pushes received write bytes into the RX FIFO.
module i2c_rx_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1111000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic [7:0] rx_data,
  input  logic       rx_fifo_full,
  output logic       rx_enable,
  output logic       sda_ack,
  output logic       rx_write,
  output logic [7:0] rx_write_data,
  output logic       rw_mode,
  output logic       tx_mode,
  output logic       busy
);

  localparam logic [3:0] IDLE          = 4'd0;
  localparam logic [3:0] ADDR_RX       = 4'd1;
  localparam logic [3:0] ADDR_CHECK    = 4'd2;
  localparam logic [3:0] ADDR_ACK_WAIT = 4'd3;
  localparam logic [3:0] ADDR_ACK      = 4'd4;
  localparam logic [3:0] DATA_RX       = 4'd5;
  localparam logic [3:0] DATA_CHECK    = 4'd6;
  localparam logic [3:0] DATA_ACK_WAIT = 4'd7;
  localparam logic [3:0] DATA_ACK      = 4'd8;
  localparam logic [3:0] NACK_WAIT     = 4'd9;
  localparam logic [3:0] TX_HOLD       = 4'd10;
  localparam logic [3:0] IGNORE        = 4'd11;

  logic [3:0] state, state_nxt;
  logic [3:0] bit_cnt;
  logic       nack_rise;
  logic       byte_done, addr_match, ovr, wr_fire, rw_latch, enter_rx;

  assign ovr        = start_found | stop_found;
  assign byte_done  = rising_edge_found & rx_enable & (bit_cnt == 4'd7);
  assign addr_match = (rx_data[7:1] == SLAVE_ADDR);
  assign wr_fire    = (state == DATA_CHECK) & ~rx_fifo_full & ~ovr;
  assign rw_latch   = (state == ADDR_CHECK) & addr_match & ~ovr;

  always_comb begin
    state_nxt = state;
    case (state)
      ADDR_RX:       if (byte_done) state_nxt = ADDR_CHECK;
      ADDR_CHECK:    state_nxt = addr_match ? ADDR_ACK_WAIT : IGNORE;
      ADDR_ACK_WAIT: if (falling_edge_found) state_nxt = ADDR_ACK;
      ADDR_ACK:      if (falling_edge_found) state_nxt = rw_mode ? TX_HOLD : DATA_RX;
      DATA_RX:       if (byte_done) state_nxt = DATA_CHECK;
      DATA_CHECK:    state_nxt = rx_fifo_full ? NACK_WAIT : DATA_ACK_WAIT;
      DATA_ACK_WAIT: if (falling_edge_found) state_nxt = DATA_ACK;
      DATA_ACK:      if (falling_edge_found) state_nxt = DATA_RX;
      // the first falling edge here closes bit 8; leave after the 9th clock
      NACK_WAIT:     if (falling_edge_found && nack_rise) state_nxt = IGNORE;
      default:       state_nxt = state;
    endcase
    if (start_found)     state_nxt = ADDR_RX;
    else if (stop_found) state_nxt = IDLE;
  end

  assign enter_rx = ((state_nxt == ADDR_RX) || (state_nxt == DATA_RX)) &&
                    ((state_nxt != state) || start_found);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= 4'd0;
      nack_rise     <= 1'b0;
      rx_enable     <= 1'b0;
      sda_ack       <= 1'b0;
      rx_write      <= 1'b0;
      rx_write_data <= 8'h00;
      rw_mode       <= 1'b0;
      tx_mode       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_found || enter_rx)
        bit_cnt <= 4'd0;
      else if (rising_edge_found && rx_enable && bit_cnt < 4'd8)
        bit_cnt <= bit_cnt + 4'd1;
      if (state != NACK_WAIT)     nack_rise <= 1'b0;
      else if (rising_edge_found) nack_rise <= 1'b1;
      rx_enable <= (state_nxt == ADDR_RX) || (state_nxt == DATA_RX);
      sda_ack   <= (state_nxt == ADDR_ACK) || (state_nxt == DATA_ACK);
      tx_mode   <= (state_nxt == TX_HOLD);
      busy      <= (state_nxt != IDLE);
      rx_write  <= wr_fire;
      if (wr_fire)  rx_write_data <= rx_data;
      if (rw_latch) rw_mode <= rx_data[0];
    end
  end

endmodule
